// File: rtl/mjpg_pkg.sv
// mjpg_pkg: constants and types shared by the MJPEG stream parser.
//   - JPEG marker codes (the byte that follows 0xFF)
//   - parser state enumeration
//   - segment length width
package mjpg_pkg;

  localparam int LEN_W = 16;

  localparam logic [7:0] MK_FF = 8'hFF;
  localparam logic [7:0] STUFF = 8'h00;
  localparam logic [7:0] TEM   = 8'h01;
  localparam logic [7:0] SOF0  = 8'hC0;
  localparam logic [7:0] RST0  = 8'hD0;
  localparam logic [7:0] RST1  = 8'hD1;
  localparam logic [7:0] RST2  = 8'hD2;
  localparam logic [7:0] RST3  = 8'hD3;
  localparam logic [7:0] RST4  = 8'hD4;
  localparam logic [7:0] RST5  = 8'hD5;
  localparam logic [7:0] RST6  = 8'hD6;
  localparam logic [7:0] RST7  = 8'hD7;
  localparam logic [7:0] SOI   = 8'hD8;
  localparam logic [7:0] EOI   = 8'hD9;
  localparam logic [7:0] SOS   = 8'hDA;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_MARK,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_SEG,
    ST_SCAN,
    ST_SCAN_FF
  } state_t;

  // RST0..RST7 share the upper five bits 11010.
  function automatic logic is_rst_code(input logic [7:0] code);
    return code[7:3] == 5'b11010;
  endfunction

endpackage

// File: rtl/mjpg_stream_parser.sv
// mjpg_stream_parser: receive side of the MJPEG byte stream.
// Hunts markers, skips header segments, captures frame height/width from the
// SOF segment and strips 0xFF00 stuffing from the entropy-coded scan data.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   jvalid, jpeg    input byte stream (no backpressure)
//   svalid, sdata   destuffed scan byte
//   sof, eoi        SOI / EOI pulses
//   scan_start      SOS segment finished, scan data follows
//   scan_end        marker terminated scan data
//   rstm            restart marker inside a scan
//   height, width   last captured SOF dimensions (truncated to DIM_W)
//   dim_valid       both dimensions captured since the last SOI
//   err             sticky protocol error, cleared by SOI
//
// All outputs are registered: a byte accepted in cycle N shows its effect in
// cycle N+1.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_HUNT    | outside any segment, looking for 0xFF
// ST_MARK    | previous byte was 0xFF, next byte is a marker code
// ST_LEN_HI  | expecting segment length high byte
// ST_LEN_LO  | expecting segment length low byte
// ST_SEG     | consuming segment payload
// ST_SCAN    | entropy-coded data, bytes pass through
// ST_SCAN_FF | scan data saw 0xFF, next byte decides stuffing/marker
module mjpg_stream_parser
  import mjpg_pkg::*;
#(
  parameter int         DIM_W    = 12,
  parameter logic [7:0] SOF_CODE = 8'hC0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jvalid,
  input  logic [7:0]       jpeg,
  output logic             svalid,
  output logic [7:0]       sdata,
  output logic             sof,
  output logic             eoi,
  output logic             scan_start,
  output logic             scan_end,
  output logic             rstm,
  output logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] width,
  output logic             dim_valid,
  output logic             err
);

  state_t             state_q, state_d;
  logic [7:0]         code_q, code_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [7:0]         dim_hi_q, dim_hi_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [2:0]         idx_q, idx_d;

  logic               svalid_d, sof_d, eoi_d, scan_start_d, scan_end_d, rstm_d;
  logic [7:0]         sdata_d;
  logic [DIM_W-1:0]   height_d, width_d;
  logic               dim_valid_d, err_d;

  logic [LEN_W-1:0]   seg_len;
  logic [15:0]        dim_full;
  logic               dim_over;
  logic               mark_byte;
  logic               seg_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      code_q     <= '0;
      len_hi_q   <= '0;
      dim_hi_q   <= '0;
      remain_q   <= '0;
      idx_q      <= '0;
      svalid     <= 1'b0;
      sdata      <= '0;
      sof        <= 1'b0;
      eoi        <= 1'b0;
      scan_start <= 1'b0;
      scan_end   <= 1'b0;
      rstm       <= 1'b0;
      height     <= '0;
      width      <= '0;
      dim_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      len_hi_q   <= len_hi_d;
      dim_hi_q   <= dim_hi_d;
      remain_q   <= remain_d;
      idx_q      <= idx_d;
      svalid     <= svalid_d;
      sdata      <= sdata_d;
      sof        <= sof_d;
      eoi        <= eoi_d;
      scan_start <= scan_start_d;
      scan_end   <= scan_end_d;
      rstm       <= rstm_d;
      height     <= height_d;
      width      <= width_d;
      dim_valid  <= dim_valid_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    len_hi_d     = len_hi_q;
    dim_hi_d     = dim_hi_q;
    remain_d     = remain_q;
    idx_d        = idx_q;
    svalid_d     = 1'b0;
    sdata_d      = sdata;
    sof_d        = 1'b0;
    eoi_d        = 1'b0;
    scan_start_d = 1'b0;
    scan_end_d   = 1'b0;
    rstm_d       = 1'b0;
    height_d     = height;
    width_d      = width;
    dim_valid_d  = dim_valid;
    err_d        = err;
    mark_byte    = 1'b0;
    seg_done     = 1'b0;
    seg_len      = {len_hi_q, jpeg};
    dim_full     = {dim_hi_q, jpeg};
    dim_over     = (32'(dim_full) >> DIM_W) != 32'd0;

    if (jvalid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (jpeg == MK_FF) state_d = ST_MARK;
        end
        ST_MARK: begin
          // Further 0xFF bytes are fill; stay until a real code arrives.
          if (jpeg != MK_FF) mark_byte = 1'b1;
        end
        ST_LEN_HI: begin
          len_hi_d = jpeg;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          idx_d = '0;
          if (seg_len < LEN_W'(2)) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end else begin
            // A SOF shorter than 7 cannot carry both dimensions.
            if (code_q == SOF_CODE && seg_len < LEN_W'(7)) err_d = 1'b1;
            remain_d = seg_len - LEN_W'(2);
            if (seg_len == LEN_W'(2)) seg_done = 1'b1;
            else                      state_d  = ST_SEG;
          end
        end
        ST_SEG: begin
          remain_d = remain_q - LEN_W'(1);
          // Payload index saturates once past the dimension fields.
          if (idx_q != 3'd5) idx_d = idx_q + 3'd1;
          if (code_q == SOF_CODE) begin
            case (idx_q)
              3'd1, 3'd3: dim_hi_d = jpeg;
              3'd2: begin
                height_d = dim_full[DIM_W-1:0];
                if (dim_over) err_d = 1'b1;
              end
              3'd4: begin
                width_d     = dim_full[DIM_W-1:0];
                dim_valid_d = 1'b1;
                if (dim_over) err_d = 1'b1;
              end
              default: ;
            endcase
          end
          if (remain_q == LEN_W'(1)) seg_done = 1'b1;
        end
        ST_SCAN: begin
          if (jpeg == MK_FF) begin
            state_d = ST_SCAN_FF;
          end else begin
            svalid_d = 1'b1;
            sdata_d  = jpeg;
          end
        end
        ST_SCAN_FF: begin
          if (jpeg == STUFF) begin
            svalid_d = 1'b1;
            sdata_d  = MK_FF;
            state_d  = ST_SCAN;
          end else if (is_rst_code(jpeg)) begin
            rstm_d  = 1'b1;
            state_d = ST_SCAN;
          end else if (jpeg != MK_FF) begin
            // Any other marker ends the scan and is then parsed as a header marker.
            scan_end_d = 1'b1;
            mark_byte  = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase

      if (mark_byte) begin
        state_d = ST_HUNT;
        if (jpeg == SOI) begin
          sof_d       = 1'b1;
          err_d       = 1'b0;
          dim_valid_d = 1'b0;
        end else if (jpeg == EOI) begin
          eoi_d = 1'b1;
        end else if (jpeg == STUFF) begin
          err_d = 1'b1;
        end else if (!(is_rst_code(jpeg) || jpeg == TEM)) begin
          code_d  = jpeg;
          state_d = ST_LEN_HI;
        end
      end

      if (seg_done) begin
        if (code_q == SOS) begin
          scan_start_d = 1'b1;
          state_d      = ST_SCAN;
        end else begin
          state_d = ST_HUNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_mjpg_stream_parser.sv
// Self-checking bench for mjpg_stream_parser: a stream-level reference model
// predicts every output for the cycle after each accepted byte; a compare
// process checks the DUT on every falling edge. Directed sections pin the
// model with hand-computed values, then randomized frames follow.
module tb_mjpg_stream_parser;

  localparam int         DIM_W    = 12;
  localparam logic [7:0] SOF_CODE = 8'hC0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             jvalid = 1'b0;
  logic [7:0]       jpeg = 8'h00;
  logic             svalid, sof, eoi, scan_start, scan_end, rstm, dim_valid, err;
  logic [7:0]       sdata;
  logic [DIM_W-1:0] height, width;

  mjpg_stream_parser #(.DIM_W(DIM_W), .SOF_CODE(SOF_CODE)) dut (
    .clk(clk), .rst(rst), .jvalid(jvalid), .jpeg(jpeg),
    .svalid(svalid), .sdata(sdata), .sof(sof), .eoi(eoi),
    .scan_start(scan_start), .scan_end(scan_end), .rstm(rstm),
    .height(height), .width(width), .dim_valid(dim_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int gap_pct = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_len_need, m_seg_left, m_pidx;
  bit         m_prev_ff, m_in_scan;
  logic [7:0] m_code, m_len_hi, m_dim_hi;
  int         m_h, m_w;
  bit         m_dv, m_err;
  bit         m_svalid, m_sof, m_eoi, m_ss, m_se, m_rstm;
  logic [7:0] m_sdata;

  task automatic m_pulses_clear();
    m_svalid = 0; m_sof = 0; m_eoi = 0; m_ss = 0; m_se = 0; m_rstm = 0;
  endtask

  task automatic m_reset();
    m_pulses_clear();
    m_len_need = 0; m_seg_left = 0; m_pidx = 0;
    m_prev_ff = 0; m_in_scan = 0;
    m_code = 0; m_len_hi = 0; m_dim_hi = 0;
    m_h = 0; m_w = 0; m_dv = 0; m_err = 0; m_sdata = 0;
  endtask

  task automatic m_marker(input logic [7:0] c);
    if (c == 8'hD8) begin m_sof = 1; m_err = 0; m_dv = 0; end
    else if (c == 8'hD9) m_eoi = 1;
    else if (c == 8'h00) m_err = 1;
    else if ((c >= 8'hD0 && c <= 8'hD7) || c == 8'h01) ;
    else begin m_code = c; m_len_need = 2; end
  endtask

  task automatic m_seg_finish();
    if (m_code == 8'hDA) begin m_in_scan = 1; m_ss = 1; end
  endtask

  task automatic m_byte(input logic [7:0] b);
    int l, v;
    m_pulses_clear();
    if (m_len_need == 2) begin
      m_len_hi = b; m_len_need = 1;
    end else if (m_len_need == 1) begin
      m_len_need = 0;
      l = int'(m_len_hi) * 256 + int'(b);
      if (l < 2) m_err = 1;
      else begin
        if (m_code == SOF_CODE && l < 7) m_err = 1;
        m_seg_left = l - 2; m_pidx = 0;
        if (m_seg_left == 0) m_seg_finish();
      end
    end else if (m_seg_left > 0) begin
      if (m_code == SOF_CODE) begin
        v = int'(m_dim_hi) * 256 + int'(b);
        if (m_pidx == 1 || m_pidx == 3) m_dim_hi = b;
        if (m_pidx == 2 || m_pidx == 4) begin
          if (v >= (1 << DIM_W)) m_err = 1;
          if (m_pidx == 2) m_h = v % (1 << DIM_W);
          else begin m_w = v % (1 << DIM_W); m_dv = 1; end
        end
      end
      m_pidx++; m_seg_left--;
      if (m_seg_left == 0) m_seg_finish();
    end else if (m_prev_ff) begin
      if (b != 8'hFF) begin
        m_prev_ff = 0;
        if (m_in_scan) begin
          if (b == 8'h00) begin m_svalid = 1; m_sdata = 8'hFF; end
          else if (b >= 8'hD0 && b <= 8'hD7) m_rstm = 1;
          else begin m_in_scan = 0; m_se = 1; m_marker(b); end
        end else m_marker(b);
      end
    end else if (b == 8'hFF) begin
      m_prev_ff = 1;
    end else if (m_in_scan) begin
      m_svalid = 1; m_sdata = b;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else if (jvalid) m_byte(jpeg);
    else m_pulses_clear();
  end

  // ---------------- compare process ----------------
  logic [7:0] got_q[$];
  int n_ss = 0, n_rstm = 0, n_both = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("svalid", int'(svalid), int'(m_svalid));
      if (m_svalid) check("sdata", int'(sdata), int'(m_sdata));
      check("sof", int'(sof), int'(m_sof));
      check("eoi", int'(eoi), int'(m_eoi));
      check("scan_start", int'(scan_start), int'(m_ss));
      check("scan_end", int'(scan_end), int'(m_se));
      check("rstm", int'(rstm), int'(m_rstm));
      check("height", int'(height), m_h);
      check("width", int'(width), m_w);
      check("dim_valid", int'(dim_valid), int'(m_dv));
      check("err", int'(err), int'(m_err));
      if (svalid) got_q.push_back(sdata);
      if (scan_start) n_ss++;
      if (rstm) n_rstm++;
      if (scan_end && sof) n_both++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    int g = 0;
    while (g < 8 && $urandom_range(0, 99) < gap_pct) begin
      jvalid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    jvalid = 1'b1;
    jpeg   = b;
    @(posedge clk); #1;
    jvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    jvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sof(input int l, input int h, input int w);
    send(8'hFF); send(SOF_CODE); send(8'(l >> 8)); send(8'(l));
    for (int i = 0; i < l - 2; i++) begin
      case (i)
        0: send(8'h08);
        1: send(8'(h >> 8));
        2: send(8'(h));
        3: send(8'(w >> 8));
        4: send(8'(w));
        default: send(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  task automatic send_sos();
    send(8'hFF); send(8'hDA); send(8'h00); send(8'h0C);
    for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 255)));
  endtask

  task automatic send_hdr(input int h, input int w);
    send(8'hFF); send(8'hD8);
    send_sof(17, h, w);
    send_sos();
  endtask

  task automatic send_random_frame();
    int l, n, k;
    send(8'hFF); send(8'hD8);
    if ($urandom_range(0, 1) == 1) begin
      l = $urandom_range(0, 8);
      send(8'hFF); send(8'hE0); send(8'h00); send(8'(l));
      for (int i = 0; i < l - 2; i++) send(8'($urandom_range(0, 255)));
    end
    k = $urandom_range(0, 3);
    send_sof(k == 0 ? 6 : (k == 1 ? 11 : 17),
             $urandom_range(0, 5000), $urandom_range(0, 5000));
    send_sos();
    n = $urandom_range(5, 40);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        send(8'hFF);
        k = $urandom_range(0, 3);
        if (k == 0) send(8'h00);
        else if (k == 1) send(8'(8'hD0 + $urandom_range(0, 7)));
        else if (k == 2) begin send(8'hFF); send(8'h00); end
        else send(8'h00);
      end else begin
        send(8'($urandom_range(0, 254)));
      end
    end
    k = $urandom_range(0, 2);
    if (k == 0) begin send(8'hFF); send(8'hD9); end
    else if (k == 2) begin send(8'hFF); send(8'h01); end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_height", int'(height), 0);
    check("rst_width", int'(width), 0);
    check("rst_sdata", int'(sdata), 0);
    check("rst_err", int'(err), 0);
    check("rst_dim_valid", int'(dim_valid), 0);
    rst = 1'b0;
    idle(2);

    // header + scan
    n_ss = 0;
    send_hdr(16'h02D0, 16'h0500);
    idle(2);
    check("hdr_height", int'(height), 720);
    check("hdr_width", int'(width), 1280);
    check("hdr_dim_valid", int'(dim_valid), 1);
    check("model_height", m_h, 720);
    check("model_width", m_w, 1280);
    check("hdr_scan_start_count", n_ss, 1);

    // stuffing
    got_q.delete();
    send(8'h12); send(8'hFF); send(8'h00); send(8'h34);
    idle(2);
    check("stuff_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("stuff_b0", int'(got_q[0]), 8'h12);
      check("stuff_b1", int'(got_q[1]), 8'hFF);
      check("stuff_b2", int'(got_q[2]), 8'h34);
    end

    // restart and fill
    got_q.delete();
    n_rstm = 0;
    send(8'hFF); send(8'hFF); send(8'hD3); send(8'h56); send(8'h78);
    idle(2);
    check("rstm_count", n_rstm, 1);
    check("rst_bytes_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("rst_b0", int'(got_q[0]), 8'h56);
      check("rst_b1", int'(got_q[1]), 8'h78);
    end

    // back-to-back frames without EOI
    n_both = 0;
    send(8'h9A); send(8'hFF); send(8'hD8);
    idle(2);
    check("b2b_both_count", n_both, 1);
    check("b2b_dim_valid", int'(dim_valid), 0);
    check("b2b_err", int'(err), 0);
    send_sof(17, 480, 640);
    idle(1);
    check("b2b_dim_valid_again", int'(dim_valid), 1);
    check("b2b_height", int'(height), 480);

    // errors
    send(8'hFF); send(8'h00);
    idle(1);
    check("err_ff00", int'(err), 1);
    send(8'hFF); send(8'hD8);
    idle(1);
    check("err_cleared1", int'(err), 0);
    send(8'hFF); send(8'hE0); send(8'h00); send(8'h01);
    idle(1);
    check("err_len1", int'(err), 1);
    send(8'h55);
    idle(1);
    check("err_len1_no_scan", int'(svalid), 0);
    send_hdr(720, 16'h1000);
    idle(1);
    check("err_width_over", int'(err), 1);
    check("err_width_trunc", int'(width), 0);
    send(8'hFF); send(8'hD8);
    idle(1);
    check("err_cleared2", int'(err), 0);

    // jvalid gaps
    gap_pct = 50;
    send_hdr(16'h02D0, 16'h0500);
    gap_pct = 0;
    idle(2);
    check("gap_height", int'(height), 720);
    check("gap_width", int'(width), 1280);
    check("gap_dim_valid", int'(dim_valid), 1);

    // reset during SEG
    send(8'hFF); send(8'hD8);
    send(8'hFF); send(SOF_CODE); send(8'h00); send(8'h11); send(8'h08); send(8'h02);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_height", int'(height), 0);
    check("mid_rst_width", int'(width), 0);
    check("mid_rst_svalid", int'(svalid), 0);
    check("mid_rst_dim_valid", int'(dim_valid), 0);
    check("mid_rst_err", int'(err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    send_hdr(100, 200);
    idle(1);
    check("post_rst_height", int'(height), 100);
    check("post_rst_width", int'(width), 200);
    check("post_rst_dim_valid", int'(dim_valid), 1);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      gap_pct = $urandom_range(0, 40);
      send_random_frame();
    end
    gap_pct = 0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
